// File: rtl/vehicle_sensor_emulator.sv
// vehicle_sensor_emulator
// Plays queued entry/exit requests out as timed S1 (outer) / S2 (inner)
// sensor waveforms, each phase held longer than the sensor debounce window.
// Optional feature: define REVERSE_ABORT_EN to let abort_req back a vehicle
// out of the gate part-way through a sequence (adds the done_abort output).
module vehicle_sensor_emulator #(
  parameter int PHASE_CYCLES = 2000000,
  parameter int GAP_CYCLES   = 2000000,
  parameter int PENDING_MAX  = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_req,
  input  logic exit_req,
  input  logic abort_req,
  output logic s1,
  output logic s2,
  output logic busy,
  output logic dir,
  output logic done_entry,
  output logic done_exit,
  output logic overflow
`ifdef REVERSE_ABORT_EN
  ,
  output logic done_abort
`endif
);

  localparam int MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PEND_W  = $clog2(PENDING_MAX + 1);

  localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_FULL  = PEND_W'(PENDING_MAX);

  typedef enum logic [3:0] {
    IDLE,
    E1,
    E2,
    E3,
    X1,
    X2,
    X3,
    GAP
`ifdef REVERSE_ABORT_EN
    ,
    E1R,
    X1R
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] ent_pend_q, ent_pend_d;
  logic [PEND_W-1:0] ext_pend_q, ext_pend_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              busy_q, busy_d;
  logic              dir_q, dir_d;
  logic              done_entry_q, done_entry_d;
  logic              done_exit_q, done_exit_d;
  logic              overflow_q, overflow_d;
  logic              abort_q, abort_d;
  logic              done_abort_q, done_abort_d;

  logic phase_end;
  logic gap_end;
  logic start_ent;
  logic start_ext;
  logic ovf_ent;
  logic ovf_ext;
  logic abort_now;

`ifndef REVERSE_ABORT_EN
  logic unused_abort_req;
  assign unused_abort_req = abort_req;
`endif

  // Next-state, sequencing, arbitration, request queues and output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ent_pend_d   = ent_pend_q;
    ext_pend_d   = ext_pend_q;
    dir_d        = dir_q;
    abort_d      = abort_q;
    done_entry_d = 1'b0;
    done_exit_d  = 1'b0;
    done_abort_d = 1'b0;
    start_ent    = 1'b0;
    start_ext    = 1'b0;
    ovf_ent      = 1'b0;
    ovf_ext      = 1'b0;
    phase_end    = (cnt_q == PHASE_LAST);
    gap_end      = (cnt_q == GAP_LAST);

`ifdef REVERSE_ABORT_EN
    abort_now = abort_q |
                (abort_req & ((state_q == E1) | (state_q == E2) |
                              (state_q == X1) | (state_q == X2)));
`else
    abort_now = 1'b0;
`endif
    abort_d = abort_now;

    case (state_q)
      IDLE: begin
        if ((ent_pend_q != '0) && ((ext_pend_q == '0) || !dir_q)) begin
          state_d   = E1;
          dir_d     = 1'b1;
          start_ent = 1'b1;
        end else if (ext_pend_q != '0) begin
          state_d   = X1;
          dir_d     = 1'b0;
          start_ext = 1'b1;
        end
      end
      E1: if (phase_end) state_d = abort_now ? GAP : E2;
      E2: begin
        if (phase_end) begin
`ifdef REVERSE_ABORT_EN
          state_d = abort_now ? E1R : E3;
`else
          state_d = E3;
`endif
        end
      end
      E3: if (phase_end) state_d = GAP;
      X1: if (phase_end) state_d = abort_now ? GAP : X2;
      X2: begin
        if (phase_end) begin
`ifdef REVERSE_ABORT_EN
          state_d = abort_now ? X1R : X3;
`else
          state_d = X3;
`endif
        end
      end
      X3: if (phase_end) state_d = GAP;
`ifdef REVERSE_ABORT_EN
      E1R: if (phase_end) state_d = GAP;
      X1R: if (phase_end) state_d = GAP;
`endif
      GAP: begin
        if (gap_end) begin
          state_d = IDLE;
          abort_d = 1'b0;
          if (abort_q)    done_abort_d = 1'b1;
          else if (dir_q) done_entry_d = 1'b1;
          else            done_exit_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)   cnt_d = '0;
    else if (state_q != IDLE) cnt_d = cnt_q + CNT_W'(1);

    case ({entry_req, start_ent})
      2'b10: begin
        if (ent_pend_q == PEND_FULL) ovf_ent = 1'b1;
        else                         ent_pend_d = ent_pend_q + PEND_W'(1);
      end
      2'b01:   ent_pend_d = ent_pend_q - PEND_W'(1);
      default: ;
    endcase

    case ({exit_req, start_ext})
      2'b10: begin
        if (ext_pend_q == PEND_FULL) ovf_ext = 1'b1;
        else                         ext_pend_d = ext_pend_q + PEND_W'(1);
      end
      2'b01:   ext_pend_d = ext_pend_q - PEND_W'(1);
      default: ;
    endcase
    overflow_d = ovf_ent | ovf_ext;

    s1_d = 1'b0;
    s2_d = 1'b0;
    case (state_d)
      E1:      s1_d = 1'b1;
      E2:      begin s1_d = 1'b1; s2_d = 1'b1; end
      E3:      s2_d = 1'b1;
      X1:      s2_d = 1'b1;
      X2:      begin s1_d = 1'b1; s2_d = 1'b1; end
      X3:      s1_d = 1'b1;
`ifdef REVERSE_ABORT_EN
      E1R:     s1_d = 1'b1;
      X1R:     s2_d = 1'b1;
`endif
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops everything and loses the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ent_pend_q   <= '0;
      ext_pend_q   <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      busy_q       <= 1'b0;
      dir_q        <= 1'b0;
      done_entry_q <= 1'b0;
      done_exit_q  <= 1'b0;
      overflow_q   <= 1'b0;
      abort_q      <= 1'b0;
      done_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ent_pend_q   <= ent_pend_d;
      ext_pend_q   <= ext_pend_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      busy_q       <= busy_d;
      dir_q        <= dir_d;
      done_entry_q <= done_entry_d;
      done_exit_q  <= done_exit_d;
      overflow_q   <= overflow_d;
      abort_q      <= abort_d;
      done_abort_q <= done_abort_d;
    end
  end

  assign s1         = s1_q;
  assign s2         = s2_q;
  assign busy       = busy_q;
  assign dir        = dir_q;
  assign done_entry = done_entry_q;
  assign done_exit  = done_exit_q;
  assign overflow   = overflow_q;

`ifdef REVERSE_ABORT_EN
  assign done_abort = done_abort_q;
`else
  logic unused_abort_state;
  assign unused_abort_state = abort_q ^ done_abort_q;
`endif

endmodule

// File: tb/tb_vehicle_sensor_emulator.sv
// tb_vehicle_sensor_emulator
// Directed bench with a per-cycle expectation queue for vehicle_sensor_emulator
// (PHASE_CYCLES=4, GAP_CYCLES=3, PENDING_MAX=3). Build with REVERSE_ABORT_EN
// defined to cover the reverse-abort feature.
module tb_vehicle_sensor_emulator;

  localparam int PHASE = 4;
  localparam int GAP   = 3;
  localparam int PMAX  = 3;

  logic clk = 1'b0;
  logic reset;
  logic entry_req, exit_req, abort_req;
  logic s1, s2, busy, dir, done_entry, done_exit, overflow;
  logic done_abort_w;

`ifdef REVERSE_ABORT_EN
  logic done_abort;
  assign done_abort_w = done_abort;
`else
  assign done_abort_w = 1'b0;
`endif

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  // expected {done_abort, overflow, done_exit, done_entry, dir, busy, s2, s1}
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  vehicle_sensor_emulator #(
    .PHASE_CYCLES(PHASE),
    .GAP_CYCLES  (GAP),
    .PENDING_MAX (PMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .entry_req (entry_req),
    .exit_req  (exit_req),
    .abort_req (abort_req),
    .s1        (s1),
    .s2        (s2),
    .busy      (busy),
    .dir       (dir),
    .done_entry(done_entry),
    .done_exit (done_exit),
    .overflow  (overflow)
`ifdef REVERSE_ABORT_EN
    ,
    .done_abort(done_abort)
`endif
  );

  function automatic logic [7:0] mk(bit vs1, bit vs2, bit vbusy, bit vdir,
                                    bit de, bit dx, bit ov, bit da);
    return {da, ov, dx, de, vdir, vbusy, vs2, vs1};
  endfunction

  function automatic logic [7:0] idleV(bit vdir);
    return mk(0, 0, 0, vdir, 0, 0, 0, 0);
  endfunction

  // Full sequence: three sensor phases, the gap, then the first IDLE cycle with its done pulse
  task automatic pushSeq(bit isEntry);
    for (int i = 0; i < PHASE; i++) expQ.push_back(mk(isEntry, !isEntry, 1, isEntry, 0, 0, 0, 0));
    for (int i = 0; i < PHASE; i++) expQ.push_back(mk(1, 1, 1, isEntry, 0, 0, 0, 0));
    for (int i = 0; i < PHASE; i++) expQ.push_back(mk(!isEntry, isEntry, 1, isEntry, 0, 0, 0, 0));
    for (int i = 0; i < GAP; i++)   expQ.push_back(mk(0, 0, 1, isEntry, 0, 0, 0, 0));
    expQ.push_back(mk(0, 0, 0, isEntry, isEntry, !isEntry, 0, 0));
  endtask

  task automatic checkNow(string tag, logic [7:0] expv);
    logic [7:0] obs;
    obs = {done_abort_w, overflow, done_exit, done_entry, dir, busy, s2, s1};
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s @%0t: observed {da,ov,dx,de,dir,busy,s2,s1}=%b expected %b",
             tag, $time, obs, expv);
    end
  endtask

  task automatic checkOutput(string tag);
    logic [7:0] expv;
    expv = expQ.pop_front();
    checkNow(tag, expv);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the queue head
  task automatic applyStimulus(bit e, bit x, bit a, string tag);
    entry_req = e;
    exit_req  = x;
    abort_req = a;
    @(posedge clk);
    #1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    abort_req = 1'b0;
    checkOutput(tag);
  endtask

  task automatic runUntilEmpty(string tag);
    while (expQ.size() > 0) applyStimulus(0, 0, 0, tag);
  endtask

  task automatic doReset(string tag);
    reset = 1'b1;
    #1;
    checkNow(tag, 8'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    abort_req = 1'b0;
    #2;
    checkNow("reset_state", 8'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single entry
    expQ.push_back(idleV(0));
    pushSeq(1);
    expQ.push_back(idleV(1));
    applyStimulus(1, 0, 0, "t1_entry");
    runUntilEmpty("t1_entry");

    // single exit
    expQ.push_back(idleV(1));
    pushSeq(0);
    expQ.push_back(idleV(0));
    applyStimulus(0, 1, 0, "t2_exit");
    runUntilEmpty("t2_exit");

    // simultaneous requests from reset: entry first, then exit
    doReset("t3_reset");
    expQ.push_back(idleV(0));
    pushSeq(1);
    pushSeq(0);
    expQ.push_back(idleV(0));
    applyStimulus(1, 1, 0, "t3_both");
    runUntilEmpty("t3_both");

    // saturation: one running plus three queued, two overflow pulses
    expQ.push_back(idleV(0));
    for (int i = 0; i < 4; i++) pushSeq(1);
    expQ.push_back(idleV(1));
    applyStimulus(1, 0, 0, "t4_first");
    for (int i = 0; i < 5; i++) begin
      if (i >= PMAX) expQ[0][6] = 1'b1;
      applyStimulus(1, 0, 0, "t4_burst");
    end
    runUntilEmpty("t4_drain");

    // reset during E2 with two pending
    expQ.push_back(idleV(1));
    pushSeq(1);
    applyStimulus(1, 0, 0, "t5_req");
    applyStimulus(1, 0, 0, "t5_req");
    applyStimulus(1, 0, 0, "t5_req");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, "t5_run");
    #2;
    reset = 1'b1;
    #1;
    checkNow("t5_async_reset", 8'b0);
    expQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 25; i++) expQ.push_back(idleV(0));
    runUntilEmpty("t5_after_reset");

`ifdef REVERSE_ABORT_EN
    // abort during E2: hold 11, reverse to 10, gap, done_abort only
    expQ.push_back(idleV(0));
    for (int i = 0; i < PHASE; i++) expQ.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < PHASE; i++) expQ.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < PHASE; i++) expQ.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < GAP; i++)   expQ.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
    expQ.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    expQ.push_back(idleV(1));
    applyStimulus(1, 0, 0, "t6_abort");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, "t6_abort");
    applyStimulus(0, 0, 1, "t6_abort");
    runUntilEmpty("t6_abort");
`else
    // abort_req has no effect without the feature
    expQ.push_back(idleV(0));
    pushSeq(1);
    expQ.push_back(idleV(1));
    applyStimulus(1, 0, 0, "t6_noabort");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, "t6_noabort");
    applyStimulus(0, 0, 1, "t6_noabort");
    runUntilEmpty("t6_noabort");
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
